// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback port arbiter: fixed priority to the ALU pipe (req0),
// with an anti-starvation FSM that force-grants the load/muldiv unit (req1).
module regfile_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned AW       = 5,
    parameter int unsigned DW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          RegWEn,
    output logic [AW-1:0] AddrD,
    output logic [DW-1:0] DataD,
    output logic          starve_evt
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        ARB_NORMAL,
        ARB_FORCE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          starve_nxt;
    logic          grant0, grant1;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        starve_nxt   = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        if (rst_n) begin
            unique case (state)
                ARB_NORMAL: begin
                    req0_ready = req0_valid;
                    req1_ready = req1_valid && !req0_valid;
                    if (req1_valid && !req1_ready) begin
                        if (wait_cnt != CW'(MAX_WAIT))
                            wait_cnt_nxt = wait_cnt + CW'(1);
                        if (wait_cnt == CW'(MAX_WAIT - 1))
                            state_nxt = ARB_FORCE;
                    end else begin
                        wait_cnt_nxt = '0;
                    end
                end
                ARB_FORCE: begin
                    // If req1 withdraws while forced, the slot falls back to req0
                    // rather than being wasted.
                    req1_ready   = req1_valid;
                    req0_ready   = req0_valid && !req1_valid;
                    starve_nxt   = req1_valid;
                    wait_cnt_nxt = '0;
                    state_nxt    = ARB_NORMAL;
                end
                default: state_nxt = ARB_NORMAL;
            endcase
        end
    end

    assign grant0 = req0_valid && req0_ready;
    assign grant1 = req1_valid && req1_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_NORMAL;
            wait_cnt   <= '0;
            starve_evt <= 1'b0;
            RegWEn     <= 1'b0;
            AddrD      <= '0;
            DataD      <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            starve_evt <= starve_nxt;
            RegWEn     <= 1'b0;
            if (grant0) begin
                AddrD  <= req0_addr;
                DataD  <= req0_data;
                RegWEn <= (req0_addr != '0);
            end else if (grant1) begin
                AddrD  <= req1_addr;
                DataD  <= req1_data;
                RegWEn <= (req1_addr != '0);
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter (MAX_WAIT=3, AW=5, DW=32).
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        RegWEn, starve_evt;
    logic [4:0]  AddrD;
    logic [31:0] DataD;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.MAX_WAIT(3), .AW(5), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_ready(req1_ready),
        .RegWEn(RegWEn), .AddrD(AddrD), .DataD(DataD), .starve_evt(starve_evt)
    );

    // Each row: inputs for one cycle, expected readies in that cycle, and the
    // expected registered outputs resulting from the previous row's cycle.
    typedef struct {
        logic        rst_n;
        logic        r0v;
        logic [4:0]  r0a;
        logic [31:0] r0d;
        logic        r1v;
        logic [4:0]  r1a;
        logic [31:0] r1d;
        logic        e_r0rdy;
        logic        e_r1rdy;
        logic        chk_regs;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_starve;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic rn, input logic r0v, input logic [4:0] r0a,
                                input logic [31:0] r0d, input logic r1v, input logic [4:0] r1a,
                                input logic [31:0] r1d, input logic e0, input logic e1,
                                input logic ck, input logic ew, input logic [4:0] ea,
                                input logic [31:0] ed, input logic es);
        vec_t v;
        v.rst_n = rn; v.r0v = r0v; v.r0a = r0a; v.r0d = r0d;
        v.r1v = r1v; v.r1a = r1a; v.r1d = r1d;
        v.e_r0rdy = e0; v.e_r1rdy = e1; v.chk_regs = ck;
        v.e_wen = ew; v.e_addr = ea; v.e_data = ed; v.e_starve = es;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic r0v, input logic [4:0] r0a,
                         input logic [31:0] r0d, input logic r1v, input logic [4:0] r1a,
                         input logic [31:0] r1d);
        rst_n = rn;
        req0_valid = r0v; req0_addr = r0a; req0_data = r0d;
        req1_valid = r1v; req1_addr = r1a; req1_data = r1d;
    endtask

    initial begin
        int g0, g1, starves, wens;

        //             rst r0v r0a r0d            r1v r1a r1d          rdy0 rdy1 ck wen addr data          stv
        tbl[0]  = mk(0, 1,  1,  32'h1,         1,  2,  32'h2,       0,   0,   0, 0,  0,   32'h0,        0);
        tbl[1]  = mk(0, 1,  1,  32'h1,         1,  2,  32'h2,       0,   0,   1, 0,  0,   32'h0,        0);
        // single req0 write, then idle with held address/data
        tbl[2]  = mk(1, 1,  5,  32'hDEADBEEF,  0,  0,  32'h0,       1,   0,   1, 0,  0,   32'h0,        0);
        tbl[3]  = mk(1, 0,  0,  32'h0,         0,  0,  32'h0,       0,   0,   1, 1,  5,   32'hDEADBEEF, 0);
        tbl[4]  = mk(1, 0,  0,  32'h0,         0,  0,  32'h0,       0,   0,   1, 0,  5,   32'hDEADBEEF, 0);
        // simultaneous requests: req0 first, req1 next cycle
        tbl[5]  = mk(1, 1,  3,  32'h33,        1,  4,  32'h44,      1,   0,   1, 0,  5,   32'hDEADBEEF, 0);
        tbl[6]  = mk(1, 0,  0,  32'h0,         1,  4,  32'h44,      0,   1,   1, 1,  3,   32'h33,       0);
        tbl[7]  = mk(1, 0,  0,  32'h0,         0,  0,  32'h0,       0,   0,   1, 1,  4,   32'h44,       0);
        // write to x0 is accepted but dropped
        tbl[8]  = mk(1, 0,  0,  32'h0,         1,  0,  32'h1234,    0,   1,   1, 0,  4,   32'h44,       0);
        tbl[9]  = mk(1, 0,  0,  32'h0,         0,  0,  32'h0,       0,   0,   1, 0,  0,   32'h1234,     0);
        // starvation: req1 blocked 3 cycles, forced on the 4th
        tbl[10] = mk(1, 1,  10, 32'h100,       1,  9,  32'h99,      1,   0,   1, 0,  0,   32'h1234,     0);
        tbl[11] = mk(1, 1,  11, 32'h101,       1,  9,  32'h99,      1,   0,   1, 1,  10,  32'h100,      0);
        tbl[12] = mk(1, 1,  12, 32'h102,       1,  9,  32'h99,      1,   0,   1, 1,  11,  32'h101,      0);
        tbl[13] = mk(1, 1,  13, 32'h103,       1,  9,  32'h99,      0,   1,   1, 1,  12,  32'h102,      0);
        tbl[14] = mk(1, 1,  13, 32'h103,       0,  0,  32'h0,       1,   0,   1, 1,  9,   32'h99,       1);
        tbl[15] = mk(1, 0,  0,  32'h0,         0,  0,  32'h0,       0,   0,   1, 1,  13,  32'h103,      0);
        // req1 withdraws while forced: req0 takes the slot, no starve pulse
        tbl[16] = mk(1, 1,  14, 32'h104,       1,  15, 32'h105,     1,   0,   1, 0,  13,  32'h103,      0);
        tbl[17] = mk(1, 1,  16, 32'h106,       1,  15, 32'h105,     1,   0,   1, 1,  14,  32'h104,      0);
        tbl[18] = mk(1, 1,  17, 32'h107,       1,  15, 32'h105,     1,   0,   1, 1,  16,  32'h106,      0);
        tbl[19] = mk(1, 1,  18, 32'h108,       0,  0,  32'h0,       1,   0,   1, 1,  17,  32'h107,      0);
        tbl[20] = mk(1, 0,  0,  32'h0,         0,  0,  32'h0,       0,   0,   1, 1,  18,  32'h108,      0);
        tbl[21] = mk(1, 0,  0,  32'h0,         0,  0,  32'h0,       0,   0,   1, 0,  18,  32'h108,      0);
        // reset while forced; afterwards counting restarts from zero
        tbl[22] = mk(1, 1,  19, 32'h109,       1,  22, 32'h112,     1,   0,   1, 0,  18,  32'h108,      0);
        tbl[23] = mk(1, 1,  20, 32'h110,       1,  22, 32'h112,     1,   0,   1, 1,  19,  32'h109,      0);
        tbl[24] = mk(1, 1,  21, 32'h111,       1,  22, 32'h112,     1,   0,   1, 1,  20,  32'h110,      0);
        tbl[25] = mk(0, 1,  23, 32'h113,       1,  22, 32'h112,     0,   0,   1, 1,  21,  32'h111,      0);
        tbl[26] = mk(1, 1,  23, 32'h113,       1,  22, 32'h112,     1,   0,   1, 0,  0,   32'h0,        0);
        tbl[27] = mk(1, 1,  24, 32'h114,       1,  22, 32'h112,     1,   0,   1, 1,  23,  32'h113,      0);
        tbl[28] = mk(1, 1,  25, 32'h115,       1,  22, 32'h112,     1,   0,   1, 1,  24,  32'h114,      0);
        tbl[29] = mk(1, 1,  26, 32'h116,       1,  22, 32'h112,     0,   1,   1, 1,  25,  32'h115,      0);
        tbl[30] = mk(1, 0,  0,  32'h0,         0,  0,  32'h0,       0,   0,   1, 1,  22,  32'h112,      1);
        tbl[31] = mk(1, 0,  0,  32'h0,         0,  0,  32'h0,       0,   0,   1, 0,  22,  32'h112,      0);

        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].rst_n, tbl[i].r0v, tbl[i].r0a, tbl[i].r0d,
                  tbl[i].r1v, tbl[i].r1a, tbl[i].r1d);
            #1;
            check("req0_ready", i, 32'(req0_ready), 32'(tbl[i].e_r0rdy));
            check("req1_ready", i, 32'(req1_ready), 32'(tbl[i].e_r1rdy));
            if (tbl[i].chk_regs) begin
                check("RegWEn",     i, 32'(RegWEn),     32'(tbl[i].e_wen));
                check("AddrD",      i, 32'(AddrD),      32'(tbl[i].e_addr));
                check("DataD",      i, DataD,           tbl[i].e_data);
                check("starve_evt", i, 32'(starve_evt), 32'(tbl[i].e_starve));
            end
        end

        // Continuous contention: req1 gets exactly one slot in every MAX_WAIT+1
        // cycles, and the write port never idles.
        g0 = 0; g1 = 0; starves = 0; wens = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            drive(1, 1, 5'(c + 1), 32'(c), 1, 5'(20 + c[1:0]), 32'hA0 + 32'(c));
            #1;
            if (c > 0) begin
                wens    += int'(RegWEn);
                starves += int'(starve_evt);
            end
            if (req0_ready) begin
                g0++;
                if (req1_ready) begin
                    tests++; errors++;
                    $display("FAIL dual_grant cycle %0d: got both ready expected one", c);
                end
            end
            if (req1_ready) g1++;
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        wens    += int'(RegWEn);
        starves += int'(starve_evt);
        check("stream_req0_grants", 100, 32'(g0), 32'd12);
        check("stream_req1_grants", 101, 32'(g1), 32'd4);
        check("stream_writes",      102, 32'(wens), 32'd16);
        check("stream_starve_evts", 103, 32'(starves), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
